regfile_alu_pipe: RTL and testbench

Parametrised register-file/ALU execution slice with a registered writeback stage and valid/ready handshakes on both sides. Each accepted operation reads two registers (or one register plus an immediate), executes the team's 4-bit ALU op set, and writes the result back to the register file one stage later. The block is the execute/writeback core of the processor datapath; decode sits upstream on the input handshake and a trace/commit monitor sits downstream on the result handshake.

---
 rtl/regfile_alu_pipe.sv | 154 +++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
// Register file + 4-bit-op ALU with a one-entry writeback stage and valid/ready on both sides.
// Define RFALU_BYPASS_EN to forward the WB result; otherwise dependent ops interlock.
module regfile_alu_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NAME_BITS  = 5,
    parameter int unsigned CTRL_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NAME_BITS-1:0]  rs1,
    input  logic [NAME_BITS-1:0]  rs2,
    input  logic [NAME_BITS-1:0]  ws_in,
    input  logic                  we_in,
    input  logic [CTRL_BITS-1:0]  op_in,
    input  logic                  imm_e,
    input  logic [DATA_WIDTH-1:0] imm_d,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [NAME_BITS-1:0]  res_ws,
    output logic                  res_we,
    output logic                  zero,
    output logic                  over,
    output logic                  c_out
);

    localparam int unsigned NumRegs = 2 ** NAME_BITS;
    localparam logic [CTRL_BITS-1:0] OpAnd = 4'b0000;
    localparam logic [CTRL_BITS-1:0] OpOr  = 4'b0001;
    localparam logic [CTRL_BITS-1:0] OpAdd = 4'b0010;
    localparam logic [CTRL_BITS-1:0] OpSge = 4'b0101;
    localparam logic [CTRL_BITS-1:0] OpSub = 4'b0110;
    localparam logic [CTRL_BITS-1:0] OpSlt = 4'b0111;
    localparam logic [CTRL_BITS-1:0] OpNor = 4'b1100;
    localparam logic [DATA_WIDTH:0]  SumOne = (DATA_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
    logic [NAME_BITS-1:0]  res_ws_q,    res_ws_d;
    logic                  res_we_q,    res_we_d;
    logic                  over_q,      over_d;
    logic                  c_out_q,     c_out_d;

    logic                  fwd_live, hazard, accept, commit;
    logic [DATA_WIDTH-1:0] rf_a, rf_b, op_a, op_b_reg, op_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH:0]   sum;
    logic                  alu_over, alu_cout;

    assign fwd_live = res_valid_q && res_we_q && (res_ws_q != '0);
    assign rf_a     = (rs1 == '0) ? '0 : regs_q[rs1];
    assign rf_b     = (rs2 == '0) ? '0 : regs_q[rs2];

`ifdef RFALU_BYPASS_EN
    assign op_a     = (fwd_live && rs1 == res_ws_q) ? res_data_q : rf_a;
    assign op_b_reg = (fwd_live && rs2 == res_ws_q) ? res_data_q : rf_b;
    assign hazard   = 1'b0;
`else
    assign op_a     = rf_a;
    assign op_b_reg = rf_b;
    // Hold a dependent op until the producer has committed to the register file.
    assign hazard   = fwd_live && ((rs1 == res_ws_q) || (!imm_e && rs2 == res_ws_q));
`endif

    assign op_b     = imm_e ? imm_d : op_b_reg;
    assign in_ready = rst && (!res_valid_q || res_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign commit   = res_valid_q && res_ready;

    always_comb begin
        alu_res  = '0;
        alu_over = 1'b0;
        alu_cout = 1'b0;
        sum      = '0;
        case (op_in)
            OpAnd: alu_res = op_a & op_b;
            OpOr:  alu_res = op_a | op_b;
            OpNor: alu_res = ~(op_a | op_b);
            OpAdd: begin
                sum      = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = sum[DATA_WIDTH-1:0];
                alu_cout = sum[DATA_WIDTH];
                alu_over = (op_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                           (alu_res[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
            end
            OpSub: begin
                sum      = {1'b0, op_a} + {1'b0, ~op_b} + SumOne;
                alu_res  = sum[DATA_WIDTH-1:0];
                alu_cout = sum[DATA_WIDTH];
                alu_over = (op_a[DATA_WIDTH-1] != op_b[DATA_WIDTH-1]) &&
                           (alu_res[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
            end
            OpSlt: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OpSge: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) >= $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ws_d    = res_ws_q;
        res_we_d    = res_we_q;
        over_d      = over_q;
        c_out_d     = c_out_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_res;
            res_ws_d    = ws_in;
            res_we_d    = we_in;
            over_d      = alu_over;
            c_out_d     = alu_cout;
        end else if (commit) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ws_q    <= '0;
            res_we_q    <= 1'b0;
            over_q      <= 1'b0;
            c_out_q     <= 1'b0;
        end else begin
            if (commit && res_we_q && (res_ws_q != '0)) begin
                regs_q[res_ws_q] <= res_data_q;
            end
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ws_q    <= res_ws_d;
            res_we_q    <= res_we_d;
            over_q      <= over_d;
            c_out_q     <= c_out_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ws    = res_ws_q;
    assign res_we    = res_we_q;
    assign over      = over_q;
    assign c_out     = c_out_q;
    assign zero      = (res_data_q == '0);

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Scoreboard bench for regfile_alu_pipe: directed ops push expected WB entries, a monitor
// pops and compares them on every result handshake.
module tb_regfile_alu_pipe;

    localparam logic [3:0] OpAnd = 4'b0000, OpOr = 4'b0001, OpAdd = 4'b0010, OpSge = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110, OpSlt = 4'b0111, OpNor = 4'b1100, OpBad = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  rs1, rs2, ws_in;
    logic        we_in, imm_e;
    logic [3:0]  op_in;
    logic [31:0] imm_d;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_ws;
    logic        res_we, zero, over, c_out;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  ws;
        logic        we;
        logic        ov;
        logic        co;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bubbles = 0;

    regfile_alu_pipe #(
        .DATA_WIDTH(32),
        .NAME_BITS (5),
        .CTRL_BITS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .ws_in    (ws_in),
        .we_in    (we_in),
        .op_in    (op_in),
        .imm_e    (imm_e),
        .imm_d    (imm_d),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_ws   (res_ws),
        .res_we   (res_we),
        .zero     (zero),
        .over     (over),
        .c_out    (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one pop per result handshake.
    always @(negedge clk) begin
        if (rst === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_ws", 32'(res_ws), 32'(e.ws));
                chk("res_we", 32'(res_we), 32'(e.we));
                chk("over", 32'(over), 32'(e.ov));
                chk("c_out", 32'(c_out), 32'(e.co));
                chk("zero", 32'(zero), 32'(e.data == 32'h0));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] w, input logic we, input logic ie,
                         input logic [31:0] imm, input logic [31:0] ed,
                         input logic eo, input logic ec);
        int n;
        exp_t e;
        op_in = op; rs1 = a; rs2 = b; ws_in = w; we_in = we; imm_e = ie; imm_d = imm;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            bubbles++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready 0 expected 1");
        end else begin
            e.data = ed; e.ws = w; e.we = we; e.ov = eo; e.co = ec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] r, input logic [31:0] ed);
        issue(OpOr, r, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, ed, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((res_valid || exp_q.size() != 0) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
        rs1 = 5'd1; rs2 = 5'd2; ws_in = 5'd3; we_in = 1'b1; op_in = OpAdd;
        imm_e = 1'b0; imm_d = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_in_ready", 32'(in_ready), 32'd0);
            chk("reset_res_valid", 32'(res_valid), 32'd0);
            chk("reset_zero", 32'(zero), 32'd1);
            chk("reset_res_data", res_data, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;

        for (int r = 1; r < 32; r++) rd(5'(r), 32'h0);
        drain();

        // Dependent chain; ops 2..4 each depend on their predecessor.
        bubbles = 0;
        issue(OpOr,  5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
        issue(OpOr,  5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 32'h0, 32'd5, 1'b0, 1'b0);
        issue(OpAdd, 5'd0, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0, 32'd5, 1'b0, 1'b0);
        issue(OpSub, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFB, 1'b0, 1'b0);
        issue(OpSlt, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0);
        issue(OpSge, 5'd1, 5'd4, 5'd6, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0, 1'b0);
`ifdef RFALU_BYPASS_EN
        chk("chain_bubbles", 32'(bubbles), 32'd0);
`else
        chk("chain_bubbles", 32'(bubbles), 32'd3);
`endif
        rd(5'd1, 32'd5); rd(5'd2, 32'd5); rd(5'd3, 32'd5);
        rd(5'd4, 32'hFFFF_FFFB); rd(5'd5, 32'd0); rd(5'd6, 32'd1);
        drain();

        // Backpressure on an ADD result.
        res_ready = 1'b0;
        issue(OpAdd, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 32'd10, 32'd15, 1'b0, 1'b0);
        op_in = OpOr; rs1 = 5'd2; rs2 = 5'd0; ws_in = 5'd8; we_in = 1'b1; imm_e = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_res_data", res_data, 32'd15);
            chk("stall_res_ws", 32'(res_ws), 32'd7);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; res_ready = 1'b1;
        rd(5'd7, 32'd15);

        // Flags and corner cases.
        issue(OpAdd, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        issue(OpAdd, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
        issue(OpAdd, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OpAdd, 5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 32'd1, 32'h0, 1'b0, 1'b1);
        issue(OpSub, 5'd9, 5'd0, 5'd12, 1'b1, 1'b1, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue(OpSub, 5'd1, 5'd0, 5'd13, 1'b1, 1'b1, 32'd3, 32'd2, 1'b0, 1'b1);
        issue(OpAnd, 5'd4, 5'd0, 5'd14, 1'b1, 1'b1, 32'hFF, 32'hFB, 1'b0, 1'b0);
        issue(OpNor, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OpOr,  5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h1234, 32'h1234, 1'b0, 1'b0);
        rd(5'd0, 32'h0);
        issue(OpBad, 5'd1, 5'd2, 5'd16, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rd(5'd16, 32'h0);
        rd(5'd12, 32'h7FFF_FFFF);
        drain();

        // Reset while a result is stalled: the entry must vanish uncommitted.
        res_ready = 1'b0;
        issue(OpAdd, 5'd0, 5'd0, 5'd17, 1'b1, 1'b1, 32'h55, 32'h55, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midreset_res_valid", 32'(res_valid), 32'd0);
        chk("midreset_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        rd(5'd17, 32'h0);
        rd(5'd1, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
